// File: rtl/mc_request_pkg.sv
// Shared types for the trace request queue: FSM states, memory op codes and
// the canonical request layout used for queue storage.
package mc_request_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int OP_READ  = 0;
  localparam int OP_WRITE = 1;
  localparam int OP_FETCH = 2;

  localparam int REQ_TAG_W   = 8;
  localparam int REQ_TIME_W  = 32;
  localparam int REQ_MEMOP_W = 4;
  localparam int REQ_ADDR_W  = 36;

  // Field order {tag, tstamp, cmd, addr} is the packing order of queue words.
  typedef struct packed {
    logic [REQ_TAG_W-1:0]   tag;
    logic [REQ_TIME_W-1:0]  tstamp;
    logic [REQ_MEMOP_W-1:0] cmd;
    logic [REQ_ADDR_W-1:0]  addr;
  } mc_req_t;

endpackage

// File: rtl/req_fifo.sv
// Synchronous FIFO with a combinational head word and an occupancy count.
module req_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      occupancy
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;

  // Pointers are exactly AW bits wide, so they wrap at DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      occupancy <= occupancy + 1'b1;
      else if (!push && pop) occupancy <= occupancy - 1'b1;
    end
  end

endmodule

// File: rtl/trace_request_queue.sv
// Replays a timestamped memory trace: validates and tags incoming entries,
// queues them, and releases each one once the CPU cycle counter reaches it.
module trace_request_queue
  import mc_request_pkg::*;
#(
  parameter int ADDR_WIDTH  = 36,
  parameter int MEMOP_WIDTH = 4,
  parameter int TIME_WIDTH  = 32,
  parameter int TAG_WIDTH   = 8,
  parameter int DEPTH       = 16,
  parameter int MAX_OPS     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TIME_WIDTH-1:0]    in_time,
  input  logic [MEMOP_WIDTH-1:0]   in_cmd,
  input  logic [ADDR_WIDTH-1:0]    in_addr,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TAG_WIDTH-1:0]     out_tag,
  output logic [TIME_WIDTH-1:0]    out_time,
  output logic [MEMOP_WIDTH-1:0]   out_cmd,
  output logic [ADDR_WIDTH-1:0]    out_addr,
  output logic                     out_late,
  output logic [TIME_WIDTH-1:0]    cycle_cnt,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err_order,
  output logic                     err_burst,
  output logic                     err_cmd,
  output logic                     done
);

  localparam int OW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(MAX_OPS + 1);
  localparam int W  = TAG_WIDTH + TIME_WIDTH + MEMOP_WIDTH + ADDR_WIDTH;

  state_t                state;
  logic [TAG_WIDTH-1:0]  tag_cnt;
  logic [TIME_WIDTH-1:0] last_time;
  logic [CW-1:0]         same_cnt;
  logic [W-1:0]          head;
  logic running, accept, bad_order, bad_burst, bad_cmd, store, pop;

  assign running   = (state == RUN) || (state == DRAIN);
  // Full blocks the push even when the head leaves in the same cycle.
  assign in_ready  = (state == RUN) && (occupancy < OW'(DEPTH));
  assign accept    = in_valid && in_ready;
  assign bad_order = in_time < last_time;
  assign bad_burst = (in_time == last_time) && (same_cnt >= CW'(MAX_OPS));
  assign bad_cmd   = in_cmd > MEMOP_WIDTH'(OP_FETCH);
  assign store     = accept && !(bad_order || bad_burst || bad_cmd);

  assign {out_tag, out_time, out_cmd, out_addr} = head;
  assign out_valid = (occupancy != '0) && (out_time <= cycle_cnt) && running;
  assign out_late  = (occupancy != '0) && (out_time < cycle_cnt);
  assign pop       = out_valid && out_ready;

  req_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (store),
    .pop       (pop),
    .wdata     ({tag_cnt, in_time, in_cmd, in_addr}),
    .rdata     (head),
    .occupancy (occupancy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      if (running && cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (accept && in_last) state <= DRAIN;
        DRAIN:   if (occupancy == '0) begin
                   state <= DONE;
                   done  <= 1'b1;
                 end
        default: ;
      endcase
    end
  end

  // Dropped entries still handshake but leave ordering/tag state untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_cnt   <= '0;
      last_time <= '0;
      same_cnt  <= '0;
      err_order <= 1'b0;
      err_burst <= 1'b0;
      err_cmd   <= 1'b0;
    end else if (accept) begin
      if (bad_order) err_order <= 1'b1;
      if (bad_burst) err_burst <= 1'b1;
      if (bad_cmd)   err_cmd   <= 1'b1;
      if (store) begin
        tag_cnt   <= tag_cnt + 1'b1;
        last_time <= in_time;
        same_cnt  <= (in_time > last_time) ? CW'(1) : same_cnt + 1'b1;
      end
    end
  end

endmodule
